// File: rtl/uart_rx_word_fifo.sv
// Show-ahead word FIFO buffering received UART words for a downstream consumer.
// Words arriving while full are dropped and flagged on a sticky overflow bit.
module uart_rx_word_fifo #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_overflow,
    input  logic                  i_clr_ovf
);

    localparam logic [ADDR_WIDTH:0]   C_FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   C_CNT_ZERO   = {(ADDR_WIDTH + 1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   C_CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ZERO   = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE    = {{(ADDR_WIDTH - 1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_overflow;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_next;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_next;
    logic [ADDR_WIDTH:0]   w_count_next;
    logic                  w_overflow_next;

    // A pop frees a slot on the same edge, so a full FIFO can still accept a push then.
    always_comb begin
        w_pop           = 1'b0;
        w_push          = 1'b0;
        w_drop          = 1'b0;
        w_wr_ptr_next   = r_wr_ptr;
        w_rd_ptr_next   = r_rd_ptr;
        w_count_next    = r_count;
        w_overflow_next = r_overflow;

        w_pop  = ~r_empty & i_ready;
        w_push = i_rx_done & (~r_full | w_pop);
        w_drop = i_rx_done & r_full & ~w_pop;

        if (w_push) begin
            w_wr_ptr_next = r_wr_ptr + C_PTR_ONE;
        end else begin
            w_wr_ptr_next = r_wr_ptr;
        end

        if (w_pop) begin
            w_rd_ptr_next = r_rd_ptr + C_PTR_ONE;
        end else begin
            w_rd_ptr_next = r_rd_ptr;
        end

        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + C_CNT_ONE;
            2'b01:   w_count_next = r_count - C_CNT_ONE;
            default: w_count_next = r_count;
        endcase

        // Setting on a drop takes priority over a coincident clear request.
        if (w_drop) begin
            w_overflow_next = 1'b1;
        end else if (i_clr_ovf) begin
            w_overflow_next = 1'b0;
        end else begin
            w_overflow_next = r_overflow;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= C_PTR_ZERO;
            r_rd_ptr   <= C_PTR_ZERO;
            r_count    <= C_CNT_ZERO;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_count    <= w_count_next;
            r_full     <= (w_count_next == C_FULL_COUNT);
            r_empty    <= (w_count_next == C_CNT_ZERO);
            r_overflow <= w_overflow_next;
        end
    end

    // Storage is deliberately left out of reset; stale words are unreachable once pointers clear.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_mem[r_wr_ptr] <= i_rx_data;
        end
    end

    assign o_data     = r_mem[r_rd_ptr];
    assign o_valid    = ~r_empty;
    assign o_count    = r_count;
    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_uart_rx_word_fifo.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_uart_rx_word_fifo;

    localparam int DW    = 24;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_rx_done;
    logic [DW-1:0] i_rx_data;
    logic          i_ready;
    logic          i_clr_ovf;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic [AW:0]   o_count;
    logic          o_full;
    logic          o_empty;
    logic          o_overflow;

    logic [DW-1:0] mq[$];
    bit            m_ovf;
    int            n_cmp;
    int            n_err;

    always #5 clk = ~clk;

    uart_rx_word_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count),
        .o_full(o_full), .o_empty(o_empty), .o_overflow(o_overflow), .i_clr_ovf(i_clr_ovf)
    );

    // Drive one clock of stimulus and advance the reference model by the same edge.
    task automatic step(input bit done, input logic [DW-1:0] d, input bit rdy, input bit clr);
        bit pop, push, drop;
        i_rx_done = done; i_rx_data = d; i_ready = rdy; i_clr_ovf = clr;
        pop  = (mq.size() != 0) && rdy;
        push = done && ((mq.size() < DEPTH) || pop);
        drop = done && !push;
        @(posedge clk); #1;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(d);
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        i_rx_done = 1'b0; i_ready = 1'b0; i_clr_ovf = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_rx_done = 1'b0; i_rx_data = '0; i_ready = 1'b0; i_clr_ovf = 1'b0;
        #2;
        n_cmp++; if (o_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", o_count); end
        n_cmp++; if ({o_empty, o_full, o_valid, o_overflow} !== 4'b1000) begin
            n_err++; $display("FAIL reset_flags: got e%b f%b v%b o%b want e1 f0 v0 o0", o_empty, o_full, o_valid, o_overflow);
        end
        i_rx_done = 1'b1; i_ready = 1'b1; i_rx_data = 24'h111111;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (o_count !== 4'd0 || o_empty !== 1'b1) begin
            n_err++; $display("FAIL reset_ignores_inputs: got count %0d empty %b want 0 1", o_count, o_empty);
        end
        i_rx_done = 1'b0; i_ready = 1'b0;
        i_rst = 1'b0;
        mq.delete(); m_ovf = 1'b0;
    endtask

    task automatic test_order();
        for (int k = 1; k <= 3; k++) step(1'b1, DW'(k), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (o_data !== DW'(k + 1) || o_count !== 4'(3 - k) || o_valid !== 1'b1) begin
                n_err++; $display("FAIL order_read%0d: got data %h count %0d want %h %0d", k, o_data, o_count, k + 1, 3 - k);
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        n_cmp++; if (o_count !== 4'd0 || o_empty !== 1'b1 || o_valid !== 1'b0) begin
            n_err++; $display("FAIL order_end: got count %0d empty %b want 0 1", o_count, o_empty);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp_w[DEPTH];
        for (int i = 0; i < DEPTH; i++) begin
            exp_w[i] = DW'($urandom);
            if (exp_w[i] == 24'hABCDEF) exp_w[i] = 24'h000000;
            step(1'b1, exp_w[i], 1'b0, 1'b0);
        end
        n_cmp++; if (o_full !== 1'b1 || o_count !== 4'd8) begin
            n_err++; $display("FAIL ovf_fill: got full %b count %0d want 1 8", o_full, o_count);
        end
        step(1'b1, 24'hABCDEF, 1'b0, 1'b0);
        n_cmp++; if (o_overflow !== 1'b1 || o_count !== 4'd8 || o_data !== exp_w[0]) begin
            n_err++; $display("FAIL ovf_drop: got ovf %b count %0d data %h want 1 8 %h", o_overflow, o_count, o_data, exp_w[0]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++; if (o_data !== exp_w[i] || o_valid !== 1'b1) begin
                n_err++; $display("FAIL ovf_drain%0d: got %h want %h", i, o_data, exp_w[i]);
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        n_cmp++; if (o_empty !== 1'b1 || o_overflow !== 1'b1) begin
            n_err++; $display("FAIL ovf_after_drain: got empty %b ovf %b want 1 1", o_empty, o_overflow);
        end
        step(1'b0, '0, 1'b0, 1'b1);
        n_cmp++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", o_overflow); end
    endtask

    task automatic test_full_simul();
        logic [DW-1:0] exp_w[DEPTH];
        for (int i = 0; i < DEPTH; i++) begin
            exp_w[i] = DW'($urandom);
            step(1'b1, exp_w[i], 1'b0, 1'b0);
        end
        step(1'b1, 24'h123456, 1'b1, 1'b0);
        n_cmp++; if (o_count !== 4'd8 || o_overflow !== 1'b0 || o_full !== 1'b1) begin
            n_err++; $display("FAIL fullsim_count: got count %0d ovf %b want 8 0", o_count, o_overflow);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            n_cmp++;
            if (o_data !== ((i == DEPTH) ? 24'h123456 : exp_w[i])) begin
                n_err++; $display("FAIL fullsim_drain%0d: got %h want %h", i, o_data, (i == DEPTH) ? 24'h123456 : exp_w[i]);
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL fullsim_end: got empty %b want 1", o_empty); end
    endtask

    task automatic test_empty_push();
        step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (o_count !== 4'd0 || o_empty !== 1'b1) begin
            n_err++; $display("FAIL empty_ready: got count %0d want 0", o_count);
        end
        step(1'b1, 24'h5A5A5A, 1'b1, 1'b0);
        n_cmp++; if (o_valid !== 1'b1 || o_data !== 24'h5A5A5A || o_count !== 4'd1) begin
            n_err++; $display("FAIL empty_push: got v%b data %h count %0d want 1 5a5a5a 1", o_valid, o_data, o_count);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (o_data !== 24'h5A5A5A) begin n_err++; $display("FAIL hold_stable: got %h want 5a5a5a", o_data); end
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, DW'($urandom), 1'b1, 1'b0);
            n_cmp++; if (o_data !== mq[0] || o_count !== 4'(mq.size()) || o_count > 4'd8) begin
                n_err++; $display("FAIL wrap%0d: got data %h count %0d want %h %0d", i, o_data, o_count, mq[0], mq.size());
            end
        end
        while (mq.size() != 0) begin
            n_cmp++; if (o_data !== mq[0]) begin n_err++; $display("FAIL wrap_drain: got %h want %h", o_data, mq[0]); end
            step(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, 24'h0BAD00, 1'b0, 1'b1);
        n_cmp++; if (o_overflow !== 1'b1 || m_ovf !== 1'b1) begin
            n_err++; $display("FAIL drop_vs_clear: got %b want 1", o_overflow);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (o_count !== 4'd5 || o_overflow !== 1'b1) begin
            n_err++; $display("FAIL pre_reset: got count %0d ovf %b want 5 1", o_count, o_overflow);
        end
        #3; i_rst = 1'b1; #2;
        n_cmp++; if (o_count !== 4'd0 || {o_empty, o_full, o_valid, o_overflow} !== 4'b1000) begin
            n_err++; $display("FAIL async_reset: got count %0d e%b f%b v%b o%b want 0 1000", o_count, o_empty, o_full, o_valid, o_overflow);
        end
        i_clr_ovf = 1'b1; i_rx_done = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0; i_clr_ovf = 1'b0; i_rx_done = 1'b0;
        mq.delete(); m_ovf = 1'b0;
        step(1'b1, 24'hC0FFEE, 1'b0, 1'b0);
        n_cmp++; if (o_count !== 4'd1 || o_data !== 24'hC0FFEE || o_valid !== 1'b1) begin
            n_err++; $display("FAIL post_reset_push: got count %0d data %h want 1 c0ffee", o_count, o_data);
        end
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) < 60), DW'($urandom), ($urandom_range(99) < 45), ($urandom_range(99) < 5));
            n_cmp++; if (o_count !== 4'(mq.size()) || o_overflow !== m_ovf) begin
                n_err++; $display("FAIL rand_state%0d: got count %0d ovf %b want %0d %b", i, o_count, o_overflow, mq.size(), m_ovf);
            end
            n_cmp++; if (o_full !== (mq.size() == DEPTH) || o_empty !== (mq.size() == 0) || o_valid !== (mq.size() != 0)) begin
                n_err++; $display("FAIL rand_flags%0d: got f%b e%b v%b for %0d words", i, o_full, o_empty, o_valid, mq.size());
            end
            if (mq.size() != 0) begin
                n_cmp++; if (o_data !== mq[0]) begin
                    n_err++; $display("FAIL rand_data%0d: got %h want %h", i, o_data, mq[0]);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        test_reset();
        @(posedge clk); #1;
        test_order();
        test_overflow();
        test_full_simul();
        test_empty_push();
        test_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
